// File: rtl/crc32_pkg.sv
// CRC32 (IEEE 802.3, reflected) constants, per-byte update function and the
// frame FSM state type shared by the stream engine.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    APPEND
  } state_t;

  function automatic logic [31:0] crc32_byte_refl(input logic [31:0] crc,
                                                  input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int unsigned b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_lane_update.sv
// Combinational CRC32 update over one beat: chains the kept lanes, lane 0 first.
module crc32_lane_update
  import crc32_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic [31:0]             crc_in,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   keep,
  output logic [31:0]             crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (keep[i]) begin
        crc_out = crc32_byte_refl(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/crc32_stream.sv
// Ethernet CRC32 stream engine: GEN appends the FCS, CHECK verifies it.
// Optional saturating verdict counters when CRC32_STREAM_STATS_EN is defined.
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int STATS_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [8*DATA_BYTES-1:0] m_data,
  output logic [DATA_BYTES-1:0]   m_keep,
  output logic                    m_last,
  output logic                    chk_valid,
  output logic                    chk_ok,
  output logic [31:0]             crc_value,
  output logic [STATS_W-1:0]      good_cnt,
  output logic [STATS_W-1:0]      bad_cnt
);

  localparam int         DW = 8 * DATA_BYTES;
  localparam logic [3:0] NB = 4'(DATA_BYTES);

  state_t                state;
  logic [31:0]           crc_reg;
  logic [31:0]           crc_next;
  logic [31:0]           fcs_next;
  logic [31:0]           pend;
  logic [DW+31:0]        pend_wide;
  logic                  mode_q;
  logic                  cur_mode;
  logic                  out_free;
  logic                  accept;
  logic                  app_done;
  logic [3:0]            rem_cnt;
  logic [3:0]            kept;
  logic [3:0]            free;
  logic [DW-1:0]         gen_data;
  logic [DATA_BYTES-1:0] gen_keep;
  logic [DW-1:0]         app_data;
  logic [DATA_BYTES-1:0] app_keep;

  assign out_free  = !m_valid || m_ready;
  assign s_ready   = out_free && (state != APPEND);
  assign accept    = s_valid && s_ready;
  assign cur_mode  = (state == IDLE) ? mode : mode_q;
  assign fcs_next  = ~crc_next;
  assign pend_wide = {{DW{1'b0}}, pend};
  assign app_done  = (rem_cnt <= NB);

  crc32_lane_update #(.DATA_BYTES(DATA_BYTES)) u_lane (
    .crc_in  (crc_reg),
    .data    (s_data),
    .keep    (s_keep),
    .crc_out (crc_next)
  );

  // Last-beat packing: FCS bytes fill the free lanes right after the kept data.
  always_comb begin
    kept = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      kept = kept + {3'b000, s_keep[i]};
    end
    free     = NB - kept;
    gen_data = s_data;
    gen_keep = s_keep;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (i >= 32'(kept) && i < 32'(kept) + 32'd4) begin
        gen_data[8*i +: 8] = fcs_next[8*(i - 32'(kept)) +: 8];
        gen_keep[i]        = 1'b1;
      end
    end
    app_data = pend_wide[DW-1:0];
    app_keep = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      app_keep[i] = (i < 32'(rem_cnt));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      crc_reg   <= CRC32_INIT;
      mode_q    <= 1'b0;
      pend      <= '0;
      rem_cnt   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_last    <= 1'b0;
      chk_valid <= 1'b0;
      chk_ok    <= 1'b0;
      crc_value <= CRC32_INIT;
    end else begin
      chk_valid <= 1'b0;
      if (state == APPEND) begin
        if (out_free) begin
          m_valid <= 1'b1;
          m_data  <= app_data;
          m_keep  <= app_keep;
          m_last  <= app_done;
          pend    <= pend_wide[DW +: 32];
          if (app_done) begin
            rem_cnt <= '0;
            state   <= IDLE;
          end else begin
            rem_cnt <= rem_cnt - NB;
          end
        end
      end else if (accept) begin
        m_valid <= 1'b1;
        if (state == IDLE) begin
          mode_q <= mode;
        end
        if (!s_last) begin
          crc_reg <= crc_next;
          m_data  <= s_data;
          m_keep  <= s_keep;
          m_last  <= 1'b0;
          state   <= RUN;
        end else if (cur_mode) begin
          crc_reg   <= CRC32_INIT;
          m_data    <= s_data;
          m_keep    <= s_keep;
          m_last    <= 1'b1;
          chk_valid <= 1'b1;
          chk_ok    <= (crc_next == CRC32_RESIDUE);
          crc_value <= ~crc_next;
          state     <= IDLE;
        end else begin
          crc_reg   <= CRC32_INIT;
          m_data    <= gen_data;
          m_keep    <= gen_keep;
          crc_value <= fcs_next;
          if (free >= 4'd4) begin
            m_last <= 1'b1;
            state  <= IDLE;
          end else begin
            m_last  <= 1'b0;
            pend    <= fcs_next >> {free, 3'b000};
            rem_cnt <= 4'd4 - free;
            state   <= APPEND;
          end
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef CRC32_STREAM_STATS_EN
  logic verdict;
  assign verdict = accept && s_last && cur_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (verdict) begin
      if (crc_next == CRC32_RESIDUE) begin
        if (good_cnt != '1) good_cnt <= good_cnt + STATS_W'(1);
      end else begin
        if (bad_cnt != '1) bad_cnt <= bad_cnt + STATS_W'(1);
      end
    end
  end
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_crc32_stream.sv
// Randomized bench for crc32_stream at DATA_BYTES = 4, 8 and 1 against a
// bit-serial CRC model and a byte-stream scoreboard.
module tb_crc32_stream;

  localparam int NI = 3;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_a      [NI];
  logic        s_valid_a   [NI];
  logic        s_last_a    [NI];
  logic        m_ready_a   [NI];
  logic [63:0] s_data_a    [NI];
  logic [7:0]  s_keep_a    [NI];
  logic        s_ready_a   [NI];
  logic        m_valid_a   [NI];
  logic        m_last_a    [NI];
  logic        chk_valid_a [NI];
  logic        chk_ok_a    [NI];
  logic [63:0] m_data_a    [NI];
  logic [7:0]  m_keep_a    [NI];
  logic [31:0] crc_value_a [NI];
  logic [15:0] good_a      [NI];
  logic [15:0] bad_a       [NI];

  logic [31:0] m_data4;
  logic [3:0]  m_keep4;
  logic [63:0] m_data8;
  logic [7:0]  m_keep8;
  logic [7:0]  m_data1;
  logic [0:0]  m_keep1;

  assign m_data_a[0] = {32'h0, m_data4};
  assign m_keep_a[0] = {4'h0, m_keep4};
  assign m_data_a[1] = m_data8;
  assign m_keep_a[1] = m_keep8;
  assign m_data_a[2] = {56'h0, m_data1};
  assign m_keep_a[2] = {7'h0, m_keep1};

  crc32_stream #(.DATA_BYTES(4), .STATS_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode_a[0]), .s_valid(s_valid_a[0]), .s_ready(s_ready_a[0]),
    .s_data(s_data_a[0][31:0]), .s_keep(s_keep_a[0][3:0]), .s_last(s_last_a[0]),
    .m_valid(m_valid_a[0]), .m_ready(m_ready_a[0]), .m_data(m_data4), .m_keep(m_keep4),
    .m_last(m_last_a[0]), .chk_valid(chk_valid_a[0]), .chk_ok(chk_ok_a[0]),
    .crc_value(crc_value_a[0]), .good_cnt(good_a[0]), .bad_cnt(bad_a[0]));

  crc32_stream #(.DATA_BYTES(8), .STATS_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .mode(mode_a[1]), .s_valid(s_valid_a[1]), .s_ready(s_ready_a[1]),
    .s_data(s_data_a[1]), .s_keep(s_keep_a[1]), .s_last(s_last_a[1]),
    .m_valid(m_valid_a[1]), .m_ready(m_ready_a[1]), .m_data(m_data8), .m_keep(m_keep8),
    .m_last(m_last_a[1]), .chk_valid(chk_valid_a[1]), .chk_ok(chk_ok_a[1]),
    .crc_value(crc_value_a[1]), .good_cnt(good_a[1]), .bad_cnt(bad_a[1]));

  crc32_stream #(.DATA_BYTES(1), .STATS_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .mode(mode_a[2]), .s_valid(s_valid_a[2]), .s_ready(s_ready_a[2]),
    .s_data(s_data_a[2][7:0]), .s_keep(s_keep_a[2][0:0]), .s_last(s_last_a[2]),
    .m_valid(m_valid_a[2]), .m_ready(m_ready_a[2]), .m_data(m_data1), .m_keep(m_keep1),
    .m_last(m_last_a[2]), .chk_valid(chk_valid_a[2]), .chk_ok(chk_ok_a[2]),
    .crc_value(crc_value_a[2]), .good_cnt(good_a[2]), .bad_cnt(bad_a[2]));

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lanes(input int k);
    return (k == 0) ? 4 : (k == 1) ? 8 : 1;
  endfunction

  // Bit-serial LFSR form of the reflected CRC32.
  function automatic logic [31:0] crc_model(input bq_t fb);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (fb[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ fb[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                 c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic bq_t digits();
    bq_t q;
    for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
    return q;
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    bq_t q;
    logic [31:0] f;
    q = p;
    f = ~crc_model(p);
    for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
    return q;
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Scoreboard: expected bytes {last_byte_flag, data}, beats per frame, verdicts.
  logic [8:0]  exp_q     [NI][$];
  int          exp_beats [NI][$];
  logic        exp_ok    [NI][$];
  int          exp_good  [NI];
  int          exp_bad   [NI];
  bit          rnd_ready [NI];
  int          beats     [NI];
  logic        stall_prev[NI];
  logic [63:0] data_prev [NI];
  logic [8:0]  ctl_prev  [NI];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NI; k++) m_ready_a[k] = rnd_ready[k] ? 1'($urandom) : 1'b1;
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        beats[k]      = 0;
        stall_prev[k] = 1'b0;
      end else begin
        if (stall_prev[k]) begin
          check("hold_valid", 64'(m_valid_a[k]), 64'd1);
          check("hold_data", m_data_a[k], data_prev[k]);
          check("hold_ctl", 64'({m_keep_a[k], m_last_a[k]}), 64'(ctl_prev[k]));
        end
        if (chk_valid_a[k]) begin
          check("chk_with_last", 64'(m_valid_a[k] && m_last_a[k]), 64'd1);
          if (exp_ok[k].size() == 0) check("chk_unexpected", 64'(chk_ok_a[k]), 64'd2);
          else check("chk_ok", 64'(chk_ok_a[k]), 64'(exp_ok[k].pop_front()));
        end
        if (m_valid_a[k] && m_ready_a[k]) begin
          logic [8:0] got;
          beats[k]++;
          for (int i = 0; i < lanes(k); i++) begin
            if (m_keep_a[k][i]) begin
              got = {m_last_a[k] && (i == lanes(k) - 1 || !m_keep_a[k][i+1]), m_data_a[k][8*i +: 8]};
              if (exp_q[k].size() == 0) check("m_byte_unexpected", 64'(got), 64'h200);
              else check("m_byte", 64'(got), 64'(exp_q[k].pop_front()));
            end
          end
          if (m_last_a[k]) begin
            if (exp_beats[k].size() == 0) check("beats_unexpected", 64'(beats[k]), 64'hFFFFFFFF);
            else check("frame_beats", 64'(beats[k]), 64'(exp_beats[k].pop_front()));
            beats[k] = 0;
          end
        end
        stall_prev[k] = m_valid_a[k] && !m_ready_a[k];
        data_prev[k]  = m_data_a[k];
        ctl_prev[k]   = {m_keep_a[k], m_last_a[k]};
      end
    end
  end

  task automatic wait_accept(input int k);
    int   n;
    logic got;
    n = 0;
    do begin
      @(negedge clk);
      got = s_ready_a[k];
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 500);
    if (!got) check("accept_timeout", 64'(got), 64'd1);
  endtask

  task automatic send_frame(input int k, input logic md, input bq_t fb);
    int          n;
    int          l;
    logic [31:0] c;
    logic [31:0] f;
    n = fb.size();
    l = lanes(k);
    c = crc_model(fb);
    f = ~c;
    for (int i = 0; i < n; i++) exp_q[k].push_back({md && (i == n - 1), fb[i]});
    if (!md) begin
      for (int i = 0; i < 4; i++) exp_q[k].push_back({i == 3, f[8*i +: 8]});
      exp_beats[k].push_back((n + 4 + l - 1) / l);
    end else begin
      exp_beats[k].push_back((n + l - 1) / l);
      exp_ok[k].push_back(c == 32'hDEBB20E3);
      if (c == 32'hDEBB20E3) exp_good[k]++;
      else                   exp_bad[k]++;
    end
    for (int b = 0; b < n; b += l) begin
      mode_a[k]    = (b == 0) ? md : 1'($urandom);
      s_valid_a[k] = 1'b1;
      s_last_a[k]  = (b + l >= n);
      for (int i = 0; i < 8; i++) begin
        s_data_a[k][8*i +: 8] = (b + i < n) ? fb[b + i] : 8'($urandom);
        s_keep_a[k][i]        = (b + i < n) && (i < l);
      end
      wait_accept(k);
    end
    s_valid_a[k] = 1'b0;
    s_last_a[k]  = 1'b0;
    check("crc_value", 64'(crc_value_a[k]), 64'(f));
  endtask

  task automatic drain();
    int n;
    int pend;
    n = 0;
    do begin
      pend = 0;
      for (int k = 0; k < NI; k++) pend += exp_q[k].size() + exp_beats[k].size() + exp_ok[k].size();
      if (pend != 0) begin
        @(posedge clk);
        #1;
        n++;
      end
    end while (pend != 0 && n < 3000);
    check("drain_pending", 64'(pend), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int k);
    check("rst_m_valid", 64'(m_valid_a[k]), 64'd0);
    check("rst_m_data", m_data_a[k], 64'd0);
    check("rst_m_keep", 64'(m_keep_a[k]), 64'd0);
    check("rst_m_last", 64'(m_last_a[k]), 64'd0);
    check("rst_chk_valid", 64'(chk_valid_a[k]), 64'd0);
    check("rst_chk_ok", 64'(chk_ok_a[k]), 64'd0);
    check("rst_crc_value", 64'(crc_value_a[k]), 64'hFFFFFFFF);
    check("rst_good_cnt", 64'(good_a[k]), 64'd0);
    check("rst_bad_cnt", 64'(bad_a[k]), 64'd0);
  endtask

  task automatic check_counters();
    for (int k = 0; k < NI; k++) begin
`ifdef CRC32_STREAM_STATS_EN
      check("good_cnt", 64'(good_a[k]), 64'(exp_good[k]));
      check("bad_cnt", 64'(bad_a[k]), 64'(exp_bad[k]));
`else
      check("good_cnt_tied", 64'(good_a[k]), 64'd0);
      check("bad_cnt_tied", 64'(bad_a[k]), 64'd0);
`endif
    end
  endtask

  initial begin
    bq_t q;
    int  c0;
    int  g0;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      mode_a[k] = 1'b0; s_valid_a[k] = 1'b0; s_last_a[k] = 1'b0;
      s_data_a[k] = '0; s_keep_a[k] = '0; m_ready_a[k] = 1'b1;
      rnd_ready[k] = 1'b0; exp_good[k] = 0; exp_bad[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_reset(k);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // GEN "123456789", 4 lanes: known FCS CBF43926, beats 31-34, 35-38, {39,26,39,F4}, {CB}.
    send_frame(0, 1'b0, digits());
    check("t1_fcs", 64'(crc_value_a[0]), 64'hCBF43926);
    drain();

    // CHECK good frame, then the same frame with bit 0 of byte 5 flipped.
    q = digits();
    for (int i = 0; i < 4; i++) q.push_back(8'(32'hCBF43926 >> (8*i)));
    send_frame(0, 1'b1, q);
    check("t2_crc_value", 64'(crc_value_a[0]), 64'h2144DF1C);
    q[5] = q[5] ^ 8'h01;
    send_frame(0, 1'b1, q);
    drain();

    // GEN, 8 lanes, 4-byte frame: data and FCS share one beat.
    q = {8'h00, 8'h01, 8'h02, 8'h03};
    send_frame(1, 1'b0, q);
    drain();

    // GEN, 1 lane: FCS bytes follow as append beats with input held off.
    send_frame(2, 1'b0, digits());
    check("t4_fcs", 64'(crc_value_a[2]), 64'hCBF43926);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_append_ready", 64'(s_ready_a[2]), 64'd0);
    end
    @(posedge clk);
    #1;
    drain();

    // 50 back-to-back good CHECK frames under random backpressure.
    g0 = exp_good[0];
    rnd_ready[0] = 1'b1;
    for (int f = 0; f < 50; f++) send_frame(0, 1'b1, with_fcs(rand_payload($urandom_range(1, 30))));
    drain();
    rnd_ready[0] = 1'b0;
    check("t5_good_frames", 64'(exp_good[0] - g0), 64'd50);
    check_counters();

    // No bubble between frames: three 2-beat CHECK frames take six cycles.
    c0 = cyc;
    for (int f = 0; f < 3; f++) send_frame(0, 1'b1, with_fcs(rand_payload(4)));
    check("b2b_cycles", 64'(cyc - c0), 64'd6);
    drain();

    // Random mix of modes, lengths, corruption and backpressure on every width.
    for (int k = 0; k < NI; k++) rnd_ready[k] = 1'b1;
    for (int k = 0; k < NI; k++) begin
      for (int f = 0; f < 15; f++) begin
        if ($urandom_range(0, 1) == 0) begin
          send_frame(k, 1'b0, rand_payload($urandom_range(1, 20)));
        end else begin
          q = with_fcs(rand_payload($urandom_range(1, 20)));
          if ($urandom_range(0, 3) == 0) begin
            int idx;
            idx = $urandom_range(0, q.size() - 1);
            q[idx] = q[idx] ^ 8'(1 << $urandom_range(0, 7));
          end
          send_frame(k, 1'b1, q);
        end
      end
    end
    drain();
    for (int k = 0; k < NI; k++) rnd_ready[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_counters();

    // Reset during beat 2 of a GEN frame, then a clean frame.
    for (int i = 0; i < 4; i++) exp_q[0].push_back({1'b0, 8'(8'h31 + i)});
    mode_a[0] = 1'b0; s_valid_a[0] = 1'b1; s_last_a[0] = 1'b0;
    s_data_a[0] = 64'h34333231; s_keep_a[0] = 8'h0F;
    wait_accept(0);
    s_data_a[0] = 64'h38373635;
    @(negedge clk);
    #1;
    rst = 1'b1;
    s_valid_a[0] = 1'b0;
    for (int k = 0; k < NI; k++) begin
      exp_good[k] = 0;
      exp_bad[k]  = 0;
    end
    #1;
    check_reset(0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(0, 1'b0, digits());
    check("t6_fcs", 64'(crc_value_a[0]), 64'hCBF43926);
    drain();
    check_counters();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
